// File: rtl/signal_formatter_pkg.sv
// Shared constants for the signal formatter: edge-select encodings and default sizing.
package signal_formatter_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int FILTER_LEN_DEFAULT  = 8;

  // True when a transition to new_level should fire a pulse under the given edge mode.
  function automatic logic edge_selected(input int pulse_edge, input logic new_level);
    case (pulse_edge)
      EDGE_RISE: return new_level;
      EDGE_FALL: return !new_level;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/signal_formatter_sync_ff.sv
// N-stage synchroniser for one asynchronous bit, cleared by the active-low async reset.
module signal_formatter_sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] chain_q;

  generate
    if (N == 1) begin : g_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain_q <= '0;
        else      chain_q <= d_i;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain_q <= '0;
        else      chain_q <= {chain_q[N-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = chain_q[N-1];

endmodule

// File: rtl/signal_formatter.sv
// Resynchronises and deglitches an external timing signal; emits a clean level and
// a one-clock pulse on the selected edge(s) of that level.
module signal_formatter
  import signal_formatter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int FILTER_LEN  = FILTER_LEN_DEFAULT,
  parameter int PULSE_EDGE  = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sync_pulse,
  output logic sig_out
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  logic       s_q;
  logic [7:0] cnt_q, cnt_d;
  logic       sig_out_q, sig_out_d;
  logic       pulse_q, pulse_d;

  signal_formatter_sync_ff #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sig_in),
    .q_o (s_q)
  );

  // Pulse is computed alongside the level update so both register on the same edge.
  always_comb begin
    cnt_d     = cnt_q;
    sig_out_d = sig_out_q;
    pulse_d   = 1'b0;
    if (s_q == sig_out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      sig_out_d = s_q;
      cnt_d     = '0;
      pulse_d   = edge_selected(PULSE_EDGE, s_q);
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      sig_out_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sig_out_q <= sig_out_d;
      pulse_q   <= pulse_d;
    end
  end

  assign sig_out    = sig_out_q;
  assign sync_pulse = pulse_q;

endmodule

// File: tb/tb_signal_formatter.sv
// Directed bench for signal_formatter: three instances (rise/fall/both pulse modes) share one input.
module tb_signal_formatter;
  timeunit 1ns;
  timeprecision 100ps;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic [2:0] pulse;
  logic [2:0] sout;

  signal_formatter #(.SYNC_STAGES(2), .FILTER_LEN(8), .PULSE_EDGE(0)) u_rise (
    .clk(clk), .rst(rst), .sig_in(sig_in), .sync_pulse(pulse[0]), .sig_out(sout[0]));
  signal_formatter #(.SYNC_STAGES(2), .FILTER_LEN(8), .PULSE_EDGE(1)) u_fall (
    .clk(clk), .rst(rst), .sig_in(sig_in), .sync_pulse(pulse[1]), .sig_out(sout[1]));
  signal_formatter #(.SYNC_STAGES(2), .FILTER_LEN(8), .PULSE_EDGE(2)) u_both (
    .clk(clk), .rst(rst), .sig_in(sig_in), .sync_pulse(pulse[2]), .sig_out(sout[2]));

  always #2.5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int pcnt[3];
  int hcnt;
  int anyhigh;
  realtime rise_t[$], fall_t[$], pr_t[$], pf_t[$];
  logic sout0_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) if (pulse[i]) pcnt[i]++;
    if (sout[0]) hcnt++;
    if ((|pulse) || (|sout)) anyhigh++;
    if (sout[0] && !sout0_prev) rise_t.push_back($realtime);
    if (!sout[0] && sout0_prev) fall_t.push_back($realtime);
    if (pulse[0]) pr_t.push_back($realtime);
    if (pulse[1]) pf_t.push_back($realtime);
    sout0_prev = sout[0];
  end

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) pcnt[i] = 0;
    hcnt = 0;
    anyhigh = 0;
    rise_t.delete();
    fall_t.delete();
    pr_t.delete();
    pf_t.delete();
    sout0_prev = sout[0];
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input realtime act, input real lo, input real hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0.1f expected %0.1f..%0.1f", nm, act, lo, hi);
    end
  endtask

  // Reset with the given input level; release lands on a falling clk edge.
  task automatic do_reset(input logic v);
    @(negedge clk);
    rst = 1'b0;
    sig_in = v;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    int len;
    int exp_high;
    int exp_pr;
    int exp_pf;
    int exp_pb;
  } vec_t;

  vec_t vecs[5];
  realtime in_rise[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1,  0,  0, 0, 0};
    vecs[1] = '{7,  0,  0, 0, 0};
    vecs[2] = '{8,  8,  1, 1, 2};
    vecs[3] = '{9,  9,  1, 1, 2};
    vecs[4] = '{20, 20, 1, 1, 2};

    // Reset held while the input toggles
    #1 rst = 1'b0;
    #1;
    chk("reset_sig_out", int'(sout), 0);
    chk("reset_pulse", int'(pulse), 0);
    @(negedge clk);
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sig_in = ~sig_in;
    end
    chk("reset_hold_outputs", anyhigh, 0);

    // Glitch / pulse-width table
    foreach (vecs[v]) begin
      do_reset(1'b0);
      repeat (5) @(negedge clk);
      clear_mon();
      sig_in = 1'b1;
      repeat (vecs[v].len) @(negedge clk);
      sig_in = 1'b0;
      repeat (40) @(negedge clk);
      chk($sformatf("len%0d_high_cycles", vecs[v].len), hcnt, vecs[v].exp_high);
      chk($sformatf("len%0d_pulses_rise", vecs[v].len), pcnt[0], vecs[v].exp_pr);
      chk($sformatf("len%0d_pulses_fall", vecs[v].len), pcnt[1], vecs[v].exp_pf);
      chk($sformatf("len%0d_pulses_both", vecs[v].len), pcnt[2], vecs[v].exp_pb);
    end

    // Latency: sig_out changes on the 10th edge counting the first sampling edge as 1
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    sig_in = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) begin
        chk("lat_e9_sig_out", int'(sout[0]), 0);
        chk("lat_e9_pulse", int'(pulse[0]), 0);
      end
      if (k == 10) begin
        chk("lat_e10_sig_out", int'(sout[0]), 1);
        chk("lat_e10_pulse_rise", int'(pulse[0]), 1);
        chk("lat_e10_pulse_fall", int'(pulse[1]), 0);
        chk("lat_e10_pulse_both", int'(pulse[2]), 1);
      end
      if (k == 11) begin
        chk("lat_e11_pulse_rise", int'(pulse[0]), 0);
        chk("lat_e11_sig_out", int'(sout[0]), 1);
      end
    end

    // Release with input already high, then reset mid-pulse
    do_reset(1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) chk("rel_hi_e9_sig_out", int'(sout[0]), 0);
      if (k == 10) begin
        chk("rel_hi_e10_sig_out", int'(sout[0]), 1);
        chk("rel_hi_e10_pulse", int'(pulse[0]), 1);
      end
    end
    rst = 1'b0;
    #1;
    chk("midpulse_rst_sig_out", int'(sout), 0);
    chk("midpulse_rst_pulse", int'(pulse), 0);
    @(negedge clk);
    sig_in = 1'b0;
    clear_mon();
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midpulse_post_release", anyhigh, 0);

    // Reset mid-count
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    sig_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midcount_rst_outputs", int'({sout, pulse}), 0);
    @(negedge clk);
    sig_in = 1'b0;
    clear_mon();
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midcount_post_release", anyhigh, 0);

    // Static input: no activity
    do_reset(1'b0);
    clear_mon();
    repeat (50) @(negedge clk);
    chk("static_low_quiet", anyhigh, 0);

    // Square wave, half-period 17361 ns, three periods
    @(negedge clk);
    rst = 1'b0;
    sig_in = 1'b0;
    #100;
    rst = 1'b1;
    #50;
    clear_mon();
    for (int p = 0; p < 3; p++) begin
      sig_in = 1'b1;
      in_rise[p] = $realtime;
      #17361;
      sig_in = 1'b0;
      #17361;
    end
    #200;
    chk("sq_rise_count", rise_t.size(), 3);
    chk("sq_fall_count", fall_t.size(), 3);
    chk("sq_pulses_rise", pcnt[0], 3);
    chk("sq_pulses_fall", pcnt[1], 3);
    chk("sq_pulses_both", pcnt[2], 6);
    if (rise_t.size() == 3 && fall_t.size() == 3 && pr_t.size() == 3 && pf_t.size() == 3) begin
      chk_rng("sq_delay", rise_t[0] - in_rise[0], 45.0, 55.0);
      chk_rng("sq_period_rise", rise_t[1] - rise_t[0], 34717.0, 34727.0);
      chk_rng("sq_period_pulse", pr_t[2] - pr_t[1], 34717.0, 34727.0);
      chk_rng("sq_high_time", fall_t[0] - rise_t[0], 17356.0, 17366.0);
      chk_rng("sq_pulse_at_rise", pr_t[0] - rise_t[0], -0.5, 0.5);
      chk_rng("sq_pulse_at_fall", pf_t[1] - fall_t[1], -0.5, 0.5);
    end else begin
      chk("sq_event_queues_complete", 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
